// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
// Shared definitions for the sequential restoring divider.
// Contents:
//   state_e       - controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand/result width
//   MAX_WIDTH     - widest supported operand width
//   DBZ_QUOTIENT  - all-ones quotient reported on divide-by-zero;
//                   users slice the low WIDTH bits
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_full_subtractor.sv
// full_subtractor
// One-bit full subtractor cell. This is the subtract-direction mirror of the
// adder cells. Chained through bin/bout, it forms a ripple-borrow subtractor.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in from the next less significant cell
//   diff out difference bit
//   bout out borrow out to the next more significant cell
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;

  // A borrow is needed when b exceeds a.
  // A borrow is also needed when a equals b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/seq_divider.sv
// seq_divider
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Ports:
//   clk         in  rising-edge clock
//   rst         in  synchronous active-high reset
//   start       in  request strobe, sampled only while idle
//   dividend    in  unsigned numerator, sampled with start
//   divisor     in  unsigned denominator, sampled with start
//   busy        out high from the accepting edge until done
//   done        out one-cycle pulse; results valid that cycle
//   quotient    out result, held until the next accepted start
//   remainder   out result, held until the next accepted start
//   div_by_zero out divide-by-zero flag for the last operation
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // The stored partial remainder is always below the divisor, so WIDTH bits
  // are enough. The extra bit exists only in the transient shifted value.
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] q_reg_q, q_reg_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH+1:0] borrow;
  logic             borrow_out;
  logic             last_step;
  logic             trial_msb_unused;

  // Restoring step: bring the next dividend bit into the partial remainder.
  // Then trial-subtract the divisor through a ripple chain of cells.
  assign shifted   = {partial_q, q_reg_q[WIDTH-1]};
  assign sub_b     = {1'b0, divisor_q};
  assign borrow[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    full_subtractor u_fs (
      .a    (shifted[i]),
      .b    (sub_b[i]),
      .bin  (borrow[i]),
      .diff (trial[i]),
      .bout (borrow[i+1])
    );
  end

  assign borrow_out = borrow[WIDTH+1];
  // When there is no borrow, trial is below the divisor and its top bit is 0.
  assign trial_msb_unused = trial[WIDTH];
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // State and datapath registers.
  // Reset clears everything, so an aborted run never produces a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      partial_q   <= '0;
      q_reg_q     <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      partial_q   <= partial_d;
      q_reg_q     <= q_reg_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic.
  // A zero divisor skips the iteration and reports straight away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic.
  // Results are captured from the final step's values.
  // Doing so lets them appear in the same cycle as done.
  always_comb begin
    cnt_d       = cnt_q;
    partial_d   = partial_q;
    q_reg_d     = q_reg_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = DBZ_QUOTIENT[WIDTH-1:0];
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            divisor_d = divisor;
            partial_d = '0;
            q_reg_d   = dividend;
            cnt_d     = '0;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!borrow_out) begin
          partial_d = trial[WIDTH-1:0];
          q_reg_d   = {q_reg_q[WIDTH-2:0], 1'b1};
        end else begin
          partial_d = shifted[WIDTH-1:0];
          q_reg_d   = {q_reg_q[WIDTH-2:0], 1'b0};
        end
        if (last_step) begin
          quotient_d  = q_reg_d;
          remainder_d = partial_d;
          dbz_d       = 1'b0;
        end
      end
      default: ;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
// Self-checking bench for seq_divider at WIDTH=4.
// It covers the following:
//   - directed vectors;
//   - mid-run start and reset corner cases;
//   - an exhaustive sweep of all operand pairs;
//   - randomized operations.
// Each result is compared against an arithmetic reference.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int nChecks = 0;
  int nFails = 0;

  typedef struct {
    int a;
    int b;
    int expQ;
    int expR;
    int expZ;
    int expLat;
    int expBusy;
  } vector_t;

  vector_t vectors[6];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Reference division computed with plain arithmetic.
  // A zero divisor yields an all-ones quotient and passes the dividend through.
  function automatic void refDiv(input int a, input int b,
                                 output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  // Compare one observed value with its expectation and keep the tallies.
  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advance one clock and land 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait for done, with a bounded wait.
  // Then step into the following idle cycle.
  // Results stay held there for inspection.
  // lat counts cycles from the start cycle to the done cycle.
  task automatic applyStimulus(input int a, input int b,
                               output int lat, output int busyCycles,
                               output int doneAfter);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    tick();
    start      = 1'b0;
    lat        = 1;
    busyCycles = 0;
    while (!done && lat < 40) begin
      if (busy) busyCycles++;
      tick();
      lat++;
    end
    if (!done) checkOutput("done_timeout", int'(done), 1);
    tick();
    doneAfter = int'(done);
  endtask

  // Run a single operation and check every result field against the model.
  task automatic runAndCheck(input int a, input int b, input string tag);
    int lat, bc, da, q, r, z;
    refDiv(a, b, q, r, z);
    applyStimulus(a, b, lat, bc, da);
    checkOutput($sformatf("%s %0d/%0d quotient", tag, a, b), int'(quotient), q);
    checkOutput($sformatf("%s %0d/%0d remainder", tag, a, b), int'(remainder), r);
    checkOutput($sformatf("%s %0d/%0d dbz", tag, a, b), int'(div_by_zero), z);
    checkOutput($sformatf("%s %0d/%0d latency", tag, a, b), lat, (z != 0) ? 1 : W + 1);
  endtask

  initial begin
    int lat, bc, da, dones, gotQ, gotR, sawDone;

    // Directed expectations, derived by hand.
    vectors[0] = '{a: 13, b: 3, expQ: 4,  expR: 1, expZ: 0, expLat: 5, expBusy: 4};
    vectors[1] = '{a: 15, b: 1, expQ: 15, expR: 0, expZ: 0, expLat: 5, expBusy: 4};
    vectors[2] = '{a: 7,  b: 9, expQ: 0,  expR: 7, expZ: 0, expLat: 5, expBusy: 4};
    vectors[3] = '{a: 0,  b: 5, expQ: 0,  expR: 0, expZ: 0, expLat: 5, expBusy: 4};
    vectors[4] = '{a: 9,  b: 0, expQ: 15, expR: 9, expZ: 1, expLat: 1, expBusy: 0};
    vectors[5] = '{a: 8,  b: 2, expQ: 4,  expR: 0, expZ: 0, expLat: 5, expBusy: 4};

    // Reset state.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset quotient", int'(quotient), 0);
    checkOutput("reset remainder", int'(remainder), 0);
    checkOutput("reset dbz", int'(div_by_zero), 0);

    // Table-driven directed vectors.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vectors[i].a, vectors[i].b, lat, bc, da);
      checkOutput($sformatf("vec%0d quotient", i), int'(quotient), vectors[i].expQ);
      checkOutput($sformatf("vec%0d remainder", i), int'(remainder), vectors[i].expR);
      checkOutput($sformatf("vec%0d dbz", i), int'(div_by_zero), vectors[i].expZ);
      checkOutput($sformatf("vec%0d latency", i), lat, vectors[i].expLat);
      checkOutput($sformatf("vec%0d busy cycles", i), bc, vectors[i].expBusy);
      checkOutput($sformatf("vec%0d done pulse width", i), da, 0);
    end

    // Two starts are issued during the 14/4 operation.
    // One arrives mid-run; the other coincides with done.
    // Operands also change while busy.
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    tick();
    dones = 0;
    gotQ  = -1;
    gotR  = -1;
    for (int i = 0; i < 12; i++) begin
      start = 1'b0;
      if (i == 1) begin
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd3;
      end
      if (i == 2) begin
        dividend = 4'd1;
        divisor  = 4'd0;
      end
      if (done) begin
        dones++;
        gotQ     = int'(quotient);
        gotR     = int'(remainder);
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd3;
      end
      tick();
    end
    start = 1'b0;
    checkOutput("ignored start quotient", gotQ, 3);
    checkOutput("ignored start remainder", gotR, 2);
    checkOutput("ignored start done count", dones, 1);
    checkOutput("ignored start not queued busy", int'(busy), 0);

    // Reset in the second RUN cycle aborts with no done pulse.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort quotient", int'(quotient), 0);
    checkOutput("abort remainder", int'(remainder), 0);
    checkOutput("abort dbz", int'(div_by_zero), 0);
    sawDone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) sawDone = 1;
      tick();
    end
    checkOutput("abort no done", sawDone, 0);
    runAndCheck(10, 3, "post-abort");

    // Reset has priority over a simultaneous start.
    dividend = 4'd5;
    divisor  = 4'd2;
    start    = 1'b1;
    rst      = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    checkOutput("rst over start busy", int'(busy), 0);
    tick();
    checkOutput("rst over start done", int'(done), 0);

    // Exhaustive sweep with back-to-back starts in each idle cycle.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        runAndCheck(a, b, "sweep");
      end
    end

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      runAndCheck(int'($urandom_range(0, (1 << W) - 1)),
                  int'($urandom_range(0, (1 << W) - 1)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
